// File: rtl/fir_decimator_out.sv
// fir_decimator_out
//   Output stage behind the FIR filter. Registers the filter enable to find
//   the cycle on which the filtered sample is valid. It drops the first
//   FIR_DEPTH samples while the filter pipeline fills. After that it keeps one
//   sample in DECIM and tags it with the OR of every tap overflow flag seen in
//   its window. Kept words go into a first-word-fall-through FIFO with a
//   valid/ready output. Words rejected because the FIFO is full are counted.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_en                filter sample strobe (capture happens one cycle later)
//   iv_din              filter output sample
//   iv_prod_overflow    per-tap product overflow flags
//   iv_sum_overflow     per-tap accumulator overflow flags
//   ov_dout, o_ovf      FIFO head sample and its overflow tag
//   o_valid, i_ready    head valid / consumer accept
//   ov_fill             FIFO occupancy, 0..FIFO_DEPTH
//   o_drop, ov_drop_cnt sticky drop flag, saturating drop count
//   i_clear             synchronous clear of the drop flag and drop count
module fir_decimator_out #(
  parameter int DATA_WIDTH = 24,
  parameter int FIR_DEPTH  = 128,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic signed [DATA_WIDTH-1:0]  iv_din,
  input  logic [FIR_DEPTH-1:0]          iv_prod_overflow,
  input  logic [FIR_DEPTH-1:0]          iv_sum_overflow,
  output logic signed [DATA_WIDTH-1:0]  ov_dout,
  output logic                          o_ovf,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   ov_fill,
  output logic                          o_drop,
  output logic [7:0]                    ov_drop_cnt,
  input  logic                          i_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = (FIR_DEPTH > 1) ? $clog2(FIR_DEPTH) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic            r_cap;
  logic [0:0]      r_state;
  logic [WW-1:0]   r_warm_cnt;
  logic [PW-1:0]   r_phase;
  logic            r_win_ovf;

  logic            w_ovf_bit;
  logic            w_phase_last;
  logic            w_keep;
  logic [DATA_WIDTH:0] w_word;

  assign w_ovf_bit    = (|iv_prod_overflow) | (|iv_sum_overflow);
  assign w_phase_last = (DECIM == 1) || (r_phase == PW'(DECIM - 1));
  assign w_keep       = r_cap && (r_state == ST_RUN) && w_phase_last;
  // The current cap's overflow bit is folded in here because win_ovf
  // only holds the bits of the earlier caps in the window.
  assign w_word       = {r_win_ovf | w_ovf_bit, iv_din};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cap      <= 1'b0;
      r_state    <= ST_FILL;
      r_warm_cnt <= '0;
      r_phase    <= '0;
      r_win_ovf  <= 1'b0;
    end else begin
      r_cap <= i_en;
      if (r_cap) begin
        if (r_state == ST_FILL) begin
          // Overflow bits seen during warm-up are deliberately dropped.
          if (r_warm_cnt == WW'(FIR_DEPTH - 1)) begin
            r_state <= ST_RUN;
          end else begin
            r_warm_cnt <= r_warm_cnt + 1'b1;
          end
        end else if (w_phase_last) begin
          r_phase   <= '0;
          r_win_ovf <= 1'b0;
        end else begin
          r_phase   <= r_phase + 1'b1;
          r_win_ovf <= r_win_ovf | w_ovf_bit;
        end
      end
    end
  end

  // FIFO
  logic [DATA_WIDTH:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;

  logic                w_valid;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [DATA_WIDTH:0] w_head;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == (AW + 1)'(FIFO_DEPTH));
  assign w_pop   = w_valid & i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = w_keep & (~w_full | w_pop);
  assign w_drop  = w_keep & w_full & ~w_pop;

  // The storage has no reset. The head is gated below instead, so the
  // outputs read 0 while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign w_head  = r_mem[r_rd_ptr];
  assign ov_dout = w_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign o_ovf   = w_valid & w_head[DATA_WIDTH];
  assign o_valid = w_valid;
  assign ov_fill = r_count;

  // Drop accounting
  logic       r_drop;
  logic [7:0] r_drop_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_drop     <= 1'b0;
      r_drop_cnt <= '0;
    end else if (i_clear) begin
      // A drop in the clear cycle is still recorded.
      r_drop     <= w_drop;
      r_drop_cnt <= {7'd0, w_drop};
    end else if (w_drop) begin
      r_drop <= 1'b1;
      if (r_drop_cnt != '1) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign o_drop      = r_drop;
  assign ov_drop_cnt = r_drop_cnt;

endmodule
